// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, largest amount first,
// with valid/ready flow control and a tag sideband that travels with each beat.
`ifndef SHIFT_MODE_LEFT
`define SHIFT_MODE_LEFT 0
`endif
`ifndef SHIFT_MODE_RIGHT
`define SHIFT_MODE_RIGHT 1
`endif
`ifndef SHIFT_MODE_BIDIRECTIONAL
`define SHIFT_MODE_BIDIRECTIONAL 2
`endif

module barrel_shifter_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_MODE = `SHIFT_MODE_BIDIRECTIONAL,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_shift,
  input  logic                          i_right,
  input  logic [1:0]                    i_op,
  input  logic [TAG_WIDTH-1:0]          i_tag,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [TAG_WIDTH-1:0]          o_tag,
  output logic                          o_busy
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned S   = SHW;
  localparam bit Bidir      = (SHIFT_MODE == `SHIFT_MODE_BIDIRECTIONAL);
  localparam bit FixedRight = (SHIFT_MODE == `SHIFT_MODE_RIGHT);

  // Direction collapses to a constant outside bidirectional mode, so the mux logic folds away.
  logic right_in;
  assign right_in = Bidir ? i_right : FixedRight;

  function automatic logic [DATA_WIDTH-1:0] stage_shift(input logic [DATA_WIDTH-1:0] d,
                                                        input logic                  en,
                                                        input int unsigned           amt,
                                                        input logic                  right,
                                                        input logic [1:0]            op);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (op)
        2'b01: begin
          // Sign is preserved by every earlier stage, so the current MSB is the fill bit.
          if (right) r = $signed(d) >>> amt;
          else       r = d << amt;
        end
        2'b10: begin
          if (right) r = (d >> amt) | (d << (DATA_WIDTH - amt));
          else       r = (d << amt) | (d >> (DATA_WIDTH - amt));
        end
        default: begin
          if (right) r = d >> amt;
          else       r = d << amt;
        end
      endcase
    end
    return r;
  endfunction

  logic [S-1:0]          valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q  [S];
  logic [DATA_WIDTH-1:0] data_d  [S];
  logic [TAG_WIDTH-1:0]  tag_q   [S];
  logic [TAG_WIDTH-1:0]  tag_d   [S];
  // Control only needs to reach the stage that consumes it last, hence S-1 entries.
  logic [SHW-1:0]        shift_q [S-1];
  logic [SHW-1:0]        shift_d [S-1];
  logic                  right_q [S-1];
  logic                  right_d [S-1];
  logic [1:0]            op_q    [S-1];
  logic [1:0]            op_d    [S-1];

  logic advance;
  assign advance = !valid_q[S-1] || i_ready;

  always_comb begin
    valid_d[0] = i_valid;
    data_d[0]  = stage_shift(i_data, i_shift[SHW-1], 1 << (SHW - 1), right_in, i_op);
    tag_d[0]   = i_tag;
    shift_d[0] = i_shift;
    right_d[0] = right_in;
    op_d[0]    = i_op;
    for (int k = 1; k < S; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = stage_shift(data_q[k-1], shift_q[k-1][SHW-1-k], 1 << (SHW - 1 - k),
                               right_q[k-1], op_q[k-1]);
      tag_d[k]   = tag_q[k-1];
    end
    for (int k = 1; k < S - 1; k++) begin
      shift_d[k] = shift_q[k-1];
      right_d[k] = right_q[k-1];
      op_d[k]    = op_q[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int k = 0; k < S; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
      for (int k = 0; k < S - 1; k++) begin
        shift_q[k] <= '0;
        right_q[k] <= 1'b0;
        op_q[k]    <= 2'b00;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < S; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
      for (int k = 0; k < S - 1; k++) begin
        shift_q[k] <= shift_d[k];
        right_q[k] <= right_d[k];
        op_q[k]    <= op_d[k];
      end
    end
  end

  assign o_ready = advance;
  assign o_valid = valid_q[S-1];
  assign o_data  = data_q[S-1];
  assign o_tag   = tag_q[S-1];
  assign o_busy  = |valid_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and randomized checks of barrel_shifter_pipe at DATA_WIDTH 32, bidirectional mode.
module tb_barrel_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_right, o_valid, i_ready, o_busy;
  logic [31:0] i_data, o_data;
  logic [4:0]  i_shift;
  logic [1:0]  i_op;
  logic [3:0]  i_tag, o_tag;

  int n_checks = 0;
  int n_fail   = 0;

  barrel_shifter_pipe dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_shift (i_shift),
    .i_right (i_right),
    .i_op    (i_op),
    .i_tag   (i_tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_tag   (o_tag),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference built on 64-bit concatenation rather than staged shifts.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic right, input logic [1:0] op);
    logic [63:0] t;
    logic [31:0] fill;
    if (op == 2'b10) begin
      if (right) begin t = {d, d} >> sh; return t[31:0]; end
      else       begin t = {d, d} << sh; return t[63:32]; end
    end
    if (!right) return d << sh;
    fill = (op == 2'b01 && d[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    return (d >> sh) | fill;
  endfunction

  task automatic run_vec(input string name, input logic [31:0] d, input logic [4:0] sh,
                         input logic r, input logic [1:0] op, input logic [3:0] tag,
                         input logic [31:0] exp);
    int n;
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_shift = sh; i_right = r; i_op = op; i_tag = tag;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble controls after acceptance; the beat in flight must not see them.
    i_valid = 1'b0; i_data = ~d; i_shift = ~sh; i_right = ~r; i_op = ~op; i_tag = ~tag;
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check_eq({name, "_data"}, o_data, exp);
    check_eq({name, "_tag"}, o_tag, tag);
    check_eq({name, "_latency"}, n, 5);
  endtask

  initial begin
    logic [35:0] q[$];
    logic [35:0] e;
    logic [31:0] held_d;
    logic [3:0]  held_t;
    logic        stalled;
    int sent, recv, cyc;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_shift = '0;
    i_right = 1'b0; i_op = 2'b00; i_tag = '0;
    #2;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_tag", o_tag, 0);
    check_eq("rst_ready", o_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_vec("lsr4",    32'h8000_0000, 5'd4,  1'b1, 2'b00, 4'h1, 32'h0800_0000);
    run_vec("asr4",    32'h8000_0000, 5'd4,  1'b1, 2'b01, 4'h2, 32'hF800_0000);
    run_vec("asl4",    32'h8000_0000, 5'd4,  1'b0, 2'b01, 4'h3, 32'h0000_0000);
    run_vec("rol1",    32'h8000_0001, 5'd1,  1'b0, 2'b10, 4'h4, 32'h0000_0003);
    run_vec("ror1",    32'h0000_0001, 5'd1,  1'b1, 2'b10, 4'h5, 32'h8000_0000);
    run_vec("ror0",    32'h1234_5678, 5'd0,  1'b1, 2'b10, 4'h6, 32'h1234_5678);
    run_vec("asl0",    32'h1234_5678, 5'd0,  1'b0, 2'b01, 4'h7, 32'h1234_5678);
    run_vec("asr31",   32'hF000_0000, 5'd31, 1'b1, 2'b01, 4'h8, 32'hFFFF_FFFF);
    run_vec("lsl4",    32'h0000_000F, 5'd4,  1'b0, 2'b00, 4'h9, 32'h0000_00F0);
    run_vec("rsv_r4",  32'h8000_0000, 5'd4,  1'b1, 2'b11, 4'hA, 32'h0800_0000);
    run_vec("ror8",    32'h1234_5678, 5'd8,  1'b1, 2'b10, 4'hB, 32'h7812_3456);
    run_vec("rol8",    32'h1234_5678, 5'd8,  1'b0, 2'b10, 4'hC, 32'h3456_7812);
    run_vec("lsr31",   32'hFFFF_FFFF, 5'd31, 1'b1, 2'b00, 4'hD, 32'h0000_0001);

    // Backpressure: 16 beats, sink stalls for 3 cycles mid-stream.
    sent = 0; recv = 0; stalled = 1'b0; held_d = '0; held_t = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      i_ready = !(c >= 10 && c < 13);
      i_valid = (sent < 16);
      i_data = sent; i_tag = sent[3:0]; i_shift = 5'd1; i_right = 1'b0; i_op = 2'b00;
      #1;
      check_eq("bp_ready", o_ready, !o_valid || i_ready);
      if (stalled) begin
        check_eq("bp_hold_data", o_data, held_d);
        check_eq("bp_hold_tag", o_tag, held_t);
      end
      stalled = o_valid && !i_ready;
      held_d = o_data; held_t = o_tag;
      if (o_valid && i_ready) begin
        check_eq("bp_data", o_data, recv << 1);
        check_eq("bp_tag", o_tag, recv % 16);
        recv++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
    check_eq("bp_count", recv, 16);

    // Reset mid-stream: flush beats in flight, none emerge afterwards.
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = 1'b1; i_data = 32'hA5A5_0000 + c; i_shift = 5'd2; i_op = 2'b00;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mrst_valid", o_valid, 0);
    check_eq("mrst_busy", o_busy, 0);
    check_eq("mrst_data", o_data, 0);
    check_eq("mrst_ready", o_ready, 1);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    recv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) recv++;
    end
    check_eq("mrst_no_output", recv, 0);

    // Random traffic against the reference model and an in-order scoreboard.
    sent = 0; recv = 0; cyc = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 40000) begin
      @(negedge clk);
      i_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      i_data  = $urandom;
      i_shift = 5'($urandom_range(0, 31));
      i_right = 1'($urandom_range(0, 1));
      i_op    = 2'($urandom_range(0, 3));
      i_tag   = sent[3:0];
      i_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check_eq("rnd_extra_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check_eq("rnd_beat", {o_tag, o_data}, e);
          recv++;
        end
      end
      if (i_valid && o_ready) begin
        q.push_back({i_tag, ref_shift(i_data, i_shift, i_right, i_op)});
        sent++;
      end
      cyc++;
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
    check_eq("rnd_sent", sent, 10000);
    check_eq("rnd_recv", recv, 10000);
    check_eq("rnd_pending", q.size(), 0);
    check_eq("rnd_idle_busy", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
